// File: rtl/csr_trap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_sequencer_if
// Description : Core-side request, CSR regfile port and redirect signals
//               shared by the sequencer and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_trap_sequencer_if;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_req;
    logic [11:0] inst_csr_addr;
    logic [31:0] inst_csr_w_data;
    logic        inst_csr_w_en;
    logic [31:0] inst_csr_r_data;
    logic [11:0] csr_addr;
    logic [31:0] csr_w_data;
    logic        csr_w_en;
    logic [31:0] csr_r_data;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Environment side: core pipeline plus regfile read data.
    modport master (
        output trap_req, trap_cause, trap_pc, trap_val, mret_req,
        output inst_csr_addr, inst_csr_w_data, inst_csr_w_en, csr_r_data,
        input  inst_csr_r_data, csr_addr, csr_w_data, csr_w_en,
        input  busy, redirect_valid, redirect_pc
    );

    modport slave (
        input  trap_req, trap_cause, trap_pc, trap_val, mret_req,
        input  inst_csr_addr, inst_csr_w_data, inst_csr_w_en, csr_r_data,
        output inst_csr_r_data, csr_addr, csr_w_data, csr_w_en,
        output busy, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/csr_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_sequencer
// Description : Arbitrates the CSR port between instructions and trap/mret
//               save-restore sequences, and produces the PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_sequencer #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
    input  logic                  clock,
    input  logic                  reset,
    csr_trap_sequencer_if.slave   bus
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_T_EPC   = 3'd1;
    localparam logic [2:0] c_T_CAUSE = 3'd2;
    localparam logic [2:0] c_T_VAL   = 3'd3;
    localparam logic [2:0] c_T_STAT  = 3'd4;
    localparam logic [2:0] c_T_VEC   = 3'd5;
    localparam logic [2:0] c_M_STAT  = 3'd6;
    localparam logic [2:0] c_M_EPC   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] cause_q, pc_q, val_q, redirect_pc_q;

    logic [11:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_wen;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_rd;
    logic [31:0] w_base;

    assign w_rd   = bus.csr_r_data;
    assign w_base = {w_rd[31:2], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cause_q       <= 32'h0;
            pc_q          <= 32'h0;
            val_q         <= 32'h0;
            redirect_pc_q <= 32'h0;
        end else begin
            if (state_q == c_IDLE && bus.trap_req) begin
                cause_q <= bus.trap_cause;
                pc_q    <= bus.trap_pc;
                val_q   <= bus.trap_val;
            end
            if (w_redirect) begin
                redirect_pc_q <= w_target;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (bus.trap_req) begin
                    state_d = c_T_EPC;
                end else if (bus.mret_req) begin
                    state_d = c_M_STAT;
                end
            end
            c_T_EPC:   state_d = c_T_CAUSE;
            c_T_CAUSE: state_d = c_T_VAL;
            c_T_VAL:   state_d = c_T_STAT;
            c_T_STAT:  state_d = c_T_VEC;
            c_T_VEC:   state_d = c_IDLE;
            c_M_STAT:  state_d = c_M_EPC;
            c_M_EPC:   state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_addr     = bus.inst_csr_addr;
        w_wdata    = bus.inst_csr_w_data;
        w_wen      = 1'b0;
        w_redirect = 1'b0;
        w_target   = w_base;
        case (state_q)
            c_IDLE: begin
                w_wen = bus.inst_csr_w_en & ~bus.trap_req & ~bus.mret_req;
            end
            c_T_EPC: begin
                w_addr  = MEPC_ADDR;
                w_wdata = {pc_q[31:2], 2'b00};
                w_wen   = 1'b1;
            end
            c_T_CAUSE: begin
                w_addr  = MCAUSE_ADDR;
                w_wdata = cause_q;
                w_wen   = 1'b1;
            end
            c_T_VAL: begin
                w_addr  = MTVAL_ADDR;
                w_wdata = val_q;
                w_wen   = 1'b1;
            end
            c_T_STAT: begin
                // Save MIE into MPIE, disable interrupts, record M-mode in MPP.
                w_addr         = MSTATUS_ADDR;
                w_wdata        = w_rd;
                w_wdata[7]     = w_rd[3];
                w_wdata[3]     = 1'b0;
                w_wdata[12:11] = 2'b11;
                w_wen          = 1'b1;
            end
            c_T_VEC: begin
                w_addr     = MTVEC_ADDR;
                w_redirect = 1'b1;
                if (w_rd[1:0] == 2'b01 && cause_q[31]) begin
                    w_target = w_base + {cause_q[29:0], 2'b00};
                end
            end
            c_M_STAT: begin
                w_addr         = MSTATUS_ADDR;
                w_wdata        = w_rd;
                w_wdata[3]     = w_rd[7];
                w_wdata[7]     = 1'b1;
                w_wdata[12:11] = 2'b11;
                w_wen          = 1'b1;
            end
            c_M_EPC: begin
                w_addr     = MEPC_ADDR;
                w_redirect = 1'b1;
            end
            default: begin
                w_wen = 1'b0;
            end
        endcase
    end

    // Reset blocks the write of the in-flight step so an aborted sequence stops cleanly.
    assign bus.csr_addr        = w_addr;
    assign bus.csr_w_data      = w_wdata;
    assign bus.csr_w_en        = w_wen & ~reset;
    assign bus.redirect_valid  = w_redirect & ~reset;
    assign bus.redirect_pc     = bus.redirect_valid ? w_target : redirect_pc_q;
    assign bus.busy            = (state_q != c_IDLE);
    assign bus.inst_csr_r_data = bus.csr_r_data;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_sequencer
// Description : Directed bench for csr_trap_sequencer with a behavioural
//               CSR regfile and a log of every regfile write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_sequencer;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] rf [0:4095];
    logic [43:0] wlog [$];

    csr_trap_sequencer_if bus ();

    csr_trap_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.csr_r_data = rf[bus.csr_addr];

    always @(posedge clock) begin
        if (bus.csr_w_en) begin
            rf[bus.csr_addr] = bus.csr_w_data;
            wlog.push_back({bus.csr_addr, bus.csr_w_data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1);
    end

    // Advance to just after the next rising edge; checks sample 3 time units later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.trap_req        = 1'b0;
        bus.trap_cause      = 32'h0;
        bus.trap_pc         = 32'h0;
        bus.trap_val        = 32'h0;
        bus.mret_req        = 1'b0;
        bus.inst_csr_addr   = 12'h0;
        bus.inst_csr_w_data = 32'h0;
        bus.inst_csr_w_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.inst_csr_w_en = 1'b1;
        step();
        step();
        #3;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        total++;
        if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect_valid actual=%b required=0", bus.redirect_valid); end
        total++;
        if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect_pc actual=%h required=0", bus.redirect_pc); end
        total++;
        if (bus.csr_w_en !== 1'b0) begin bad++; $display("FAIL reset_csr_w_en actual=%b required=0", bus.csr_w_en); end
        bus.inst_csr_w_en = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    // Starts in an IDLE cycle, ends in the IDLE cycle after the redirect.
    task automatic test_trap(input string nm, input logic [31:0] cause, input logic [31:0] pc,
                             input logic [31:0] val, input logic [31:0] mtvec,
                             input logic [31:0] exp_epc, input logic [31:0] exp_pc,
                             input bit with_inst);
        logic [43:0] exp_w [4];
        exp_w[0] = {12'h341, exp_epc};
        exp_w[1] = {12'h342, cause};
        exp_w[2] = {12'h343, val};
        exp_w[3] = {12'h300, 32'h0000_1880};
        rf[12'h305] = mtvec;
        rf[12'h300] = 32'h0000_0008;
        rf[12'h340] = 32'h0;
        wlog.delete();
        bus.trap_req   = 1'b1;
        bus.trap_cause = cause;
        bus.trap_pc    = pc;
        bus.trap_val   = val;
        if (with_inst) begin
            bus.mret_req        = 1'b1;
            bus.inst_csr_addr   = 12'h340;
            bus.inst_csr_w_data = 32'h55;
            bus.inst_csr_w_en   = 1'b1;
        end
        #3;
        total++;
        if (bus.csr_w_en !== 1'b0) begin bad++; $display("FAIL %s accept_w_en actual=%b required=0", nm, bus.csr_w_en); end
        step();
        bus.trap_req = 1'b0;
        bus.mret_req = 1'b0;
        bus.trap_cause = 32'hFFFF_FFFF;
        for (int k = 1; k <= 5; k++) begin
            #3;
            total++;
            if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_c%0d actual=%b required=1", nm, k, bus.busy); end
            total++;
            if (bus.redirect_valid !== (k == 5)) begin
                bad++; $display("FAIL %s redirect_valid_c%0d actual=%b required=%b", nm, k, bus.redirect_valid, (k == 5));
            end
            if (k == 5) begin
                total++;
                if (bus.redirect_pc !== exp_pc) begin bad++; $display("FAIL %s redirect_pc actual=%h required=%h", nm, bus.redirect_pc, exp_pc); end
            end
            step();
        end
        bus.inst_csr_w_en = 1'b0;
        #3;
        total++;
        if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            bad++; $display("FAIL %s idle_after busy=%b redirect_valid=%b required=0/0", nm, bus.busy, bus.redirect_valid);
        end
        total++;
        if (bus.redirect_pc !== exp_pc) begin bad++; $display("FAIL %s redirect_pc_hold actual=%h required=%h", nm, bus.redirect_pc, exp_pc); end
        total++;
        if (wlog.size() != 4) begin
            bad++; $display("FAIL %s write_count actual=%0d required=4", nm, wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wlog[i] !== exp_w[i]) begin
                    bad++; $display("FAIL %s write%0d actual=%h required=%h", nm, i, wlog[i], exp_w[i]);
                end
            end
        end
        if (with_inst) begin
            total++;
            if (rf[12'h340] !== 32'h0) begin bad++; $display("FAIL %s mscratch actual=%h required=0", nm, rf[12'h340]); end
        end
        #2;
    endtask

    task automatic test_mret();
        rf[12'h300] = 32'h0000_1880;
        rf[12'h341] = 32'h0000_0104;
        wlog.delete();
        bus.mret_req = 1'b1;
        step();
        bus.mret_req = 1'b0;
        #3;
        total++;
        if (bus.busy !== 1'b1 || bus.csr_w_en !== 1'b1 || bus.csr_w_data !== 32'h0000_1888) begin
            bad++; $display("FAIL mret_stat busy=%b w_en=%b data=%h required=1/1/00001888", bus.busy, bus.csr_w_en, bus.csr_w_data);
        end
        total++;
        if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL mret_early_redirect actual=%b required=0", bus.redirect_valid); end
        step();
        #3;
        total++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_0104) begin
            bad++; $display("FAIL mret_redirect valid=%b pc=%h required=1/00000104", bus.redirect_valid, bus.redirect_pc);
        end
        total++;
        if (bus.csr_w_en !== 1'b0) begin bad++; $display("FAIL mret_epc_w_en actual=%b required=0", bus.csr_w_en); end
        step();
        #3;
        total++;
        if (rf[12'h300] !== 32'h0000_1888 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mret_done mstatus=%h busy=%b required=00001888/0", rf[12'h300], bus.busy);
        end
        #2;
    endtask

    task automatic test_idle_inst();
        bus.inst_csr_addr   = 12'h340;
        bus.inst_csr_w_data = 32'hA5A5_A5A5;
        bus.inst_csr_w_en   = 1'b1;
        #3;
        total++;
        if (bus.csr_w_en !== 1'b1 || bus.csr_addr !== 12'h340 || bus.csr_w_data !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL inst_write w_en=%b addr=%h data=%h required=1/340/a5a5a5a5", bus.csr_w_en, bus.csr_addr, bus.csr_w_data);
        end
        step();
        bus.inst_csr_w_en = 1'b0;
        #3;
        total++;
        if (bus.inst_csr_r_data !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL inst_read actual=%h required=a5a5a5a5", bus.inst_csr_r_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        rf[12'h341] = 32'h0;
        rf[12'h342] = 32'h77;
        rf[12'h305] = 32'h400;
        bus.trap_req   = 1'b1;
        bus.trap_cause = 32'h5;
        bus.trap_pc    = 32'h200;
        bus.trap_val   = 32'h9;
        step();
        bus.trap_req = 1'b0;
        step();
        reset = 1'b1;
        #3;
        total++;
        if (bus.csr_w_en !== 1'b0) begin bad++; $display("FAIL rst_mid_w_en actual=%b required=0", bus.csr_w_en); end
        step();
        reset = 1'b0;
        #3;
        total++;
        if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_idle busy=%b redirect_valid=%b required=0/0", bus.busy, bus.redirect_valid);
        end
        total++;
        if (rf[12'h341] !== 32'h200 || rf[12'h342] !== 32'h77) begin
            bad++; $display("FAIL rst_mid_csrs mepc=%h mcause=%h required=00000200/00000077", rf[12'h341], rf[12'h342]);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            #3;
            total++;
            if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL rst_mid_quiet%0d redirect_valid=%b busy=%b required=0/0", k, bus.redirect_valid, bus.busy);
            end
        end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4096; i++) rf[i] = 32'h0;
        clear_inputs();
        test_reset();
        test_trap("direct",  32'h2,         32'h100, 32'hDEAD, 32'h401 - 32'h1, 32'h100, 32'h400, 1'b0);
        test_trap("vec_irq", 32'h8000_0007, 32'h103, 32'h1,    32'h401, 32'h100, 32'h41C, 1'b0);
        test_trap("vec_exc", 32'h2,         32'h100, 32'h2,    32'h401, 32'h100, 32'h400, 1'b0);
        test_trap("mode11",  32'h8000_0007, 32'h208, 32'h3,    32'h403, 32'h208, 32'h400, 1'b0);
        test_mret();
        test_trap("combo",   32'h2,         32'h100, 32'hBEEF, 32'h400, 32'h100, 32'h400, 1'b1);
        test_idle_inst();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
